network_interface: RTL

Processing-element-side network interface for the mesh NoC. Sits between a PE and the router's `pe` port: it packs PE requests into header-tagged flits and injects them under credit-based flow control, and it buffers flits ejected by the router and returns one credit per flit the PE consumes. One instance per mesh node, connected back-to-back with that node's router.

---
 rtl/network_interface_pkg.sv | 41 ++++
 rtl/ni_fifo.sv | 79 +++++++
 rtl/network_interface.sv | 109 ++++++++++
 3 files changed

// File: rtl/network_interface_pkg.sv
// -----------------------------------------------------------------------------
// network_interface_pkg
// Flit layout and helpers shared by the NoC network interface, its FIFO and
// the mesh router.
//   Flit (CHANNEL_WIDTH = 32):
//     [31] valid  [30] done  [29:27] dest x  [26:24] dest y  [23:0] payload
// -----------------------------------------------------------------------------
package network_interface_pkg;

    localparam int CHANNEL_WIDTH  = 32;
    localparam int COORD_WIDTH    = 3;
    localparam int PAYLOAD_WIDTH  = 24;
    localparam int FLIT_VALID_BIT = 31;
    localparam int FLIT_DONE_BIT  = 30;
    localparam int DEST_X_MSB     = 29;
    localparam int DEST_X_LSB     = 27;
    localparam int DEST_Y_MSB     = 26;
    localparam int DEST_Y_LSB     = 24;

    typedef struct packed {
        logic                     valid;
        logic                     done;
        logic [COORD_WIDTH-1:0]   dest_x;
        logic [COORD_WIDTH-1:0]   dest_y;
        logic [PAYLOAD_WIDTH-1:0] payload;
    } flit_t;

    // Builds a single-flit packet header: valid set, done clear.
    function automatic flit_t pack_flit(input logic [COORD_WIDTH-1:0]   dest_x,
                                        input logic [COORD_WIDTH-1:0]   dest_y,
                                        input logic [PAYLOAD_WIDTH-1:0] payload);
        flit_t f;
        f.valid   = 1'b1;
        f.done    = 1'b0;
        f.dest_x  = dest_x;
        f.dest_y  = dest_y;
        f.payload = payload;
        return f;
    endfunction

endpackage

// File: rtl/ni_fifo.sv
// -----------------------------------------------------------------------------
// ni_fifo
// Parameterized synchronous FIFO with full/empty flags. Push and pop may occur
// in the same cycle; a push while full is accepted only if a pop frees a slot.
//   clk, reset    : clock, asynchronous active-low reset
//   push, din     : write request and data
//   pop           : read request (ignored when empty)
//   dout          : head entry (combinational read)
//   full, empty   : occupancy flags
// -----------------------------------------------------------------------------
module ni_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr_q];

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
        if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; the pointers and count define which entries
    // are meaningful, so clearing the array would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/network_interface.sv
// -----------------------------------------------------------------------------
// network_interface
// PE-side network interface for one mesh node. Packs PE requests into flits
// and injects them under credit-based flow control; buffers ejected flits and
// returns one credit per flit the PE consumes.
//   clk, reset                        : clock, asynchronous active-low reset
//   pe_inj_valid/ready/dest_x/dest_y/payload : PE injection handshake
//   channel_pe_dout, credit_in_din    : flit to router, credit from router
//   channel_pe_din, credit_out_dout   : flit from router, credit to router
//   pe_ej_valid/ready/flit            : PE ejection handshake (FIFO head)
//   overflow_err                      : sticky, flit arrived with FIFO full
// -----------------------------------------------------------------------------
module network_interface
    import network_interface_pkg::*;
#(
    parameter int X_LOCAL      = 2,
    parameter int Y_LOCAL      = 2,
    parameter int BUFFER_DEPTH = 4,
    parameter int CREDIT_WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pe_inj_valid,
    output logic                     pe_inj_ready,
    input  logic [COORD_WIDTH-1:0]   pe_inj_dest_x,
    input  logic [COORD_WIDTH-1:0]   pe_inj_dest_y,
    input  logic [PAYLOAD_WIDTH-1:0] pe_inj_payload,
    output logic [CHANNEL_WIDTH-1:0] channel_pe_dout,
    input  logic                     credit_in_din,
    input  logic [CHANNEL_WIDTH-1:0] channel_pe_din,
    output logic                     credit_out_dout,
    output logic                     pe_ej_valid,
    input  logic                     pe_ej_ready,
    output logic [CHANNEL_WIDTH-1:0] pe_ej_flit,
    output logic                     overflow_err
);

    localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(BUFFER_DEPTH);

    logic [CREDIT_WIDTH-1:0]  credit_cnt_q, credit_cnt_d;
    logic [CHANNEL_WIDTH-1:0] channel_q, channel_d;
    logic                     credit_out_q, credit_out_d;
    logic                     overflow_q, overflow_d;
    logic                     send, ej_push, ej_pop, ej_full, ej_empty;

    // ---------------- Injection ----------------
    assign pe_inj_ready = (credit_cnt_q != '0);
    assign send         = pe_inj_valid & pe_inj_ready;

    always_comb begin
        credit_cnt_d = credit_cnt_q;
        channel_d    = '0;
        if (send) channel_d = pack_flit(pe_inj_dest_x, pe_inj_dest_y, pe_inj_payload);
        // A returning credit and a send in the same cycle cancel out. A credit
        // at full count is a protocol violation and is dropped.
        if (send && !credit_in_din)
            credit_cnt_d = credit_cnt_q - 1'b1;
        else if (!send && credit_in_din && credit_cnt_q != CREDIT_MAX)
            credit_cnt_d = credit_cnt_q + 1'b1;
    end

    // ---------------- Ejection ----------------
    assign ej_push     = channel_pe_din[FLIT_VALID_BIT];
    assign ej_pop      = pe_ej_valid & pe_ej_ready;
    assign pe_ej_valid = ~ej_empty;

    ni_fifo #(
        .WIDTH (CHANNEL_WIDTH),
        .DEPTH (BUFFER_DEPTH)
    ) u_ej_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (ej_push),
        .din   (channel_pe_din),
        .pop   (ej_pop),
        .dout  (pe_ej_flit),
        .full  (ej_full),
        .empty (ej_empty)
    );

    always_comb begin
        credit_out_d = ej_pop;
        // A same-cycle pop frees the slot, so only an unmatched push is lost.
        overflow_d   = overflow_q | (ej_push & ej_full & ~ej_pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            credit_cnt_q <= CREDIT_MAX;
            channel_q    <= '0;
            credit_out_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            credit_cnt_q <= credit_cnt_d;
            channel_q    <= channel_d;
            credit_out_q <= credit_out_d;
            overflow_q   <= overflow_d;
        end
    end

    assign channel_pe_dout = channel_q;
    assign credit_out_dout = credit_out_q;
    assign overflow_err    = overflow_q;

    // The local address is reserved for the source field of multi-flit
    // packets; single-flit headers carry only the destination.
    localparam int UNUSED_LOCAL = X_LOCAL + Y_LOCAL;

endmodule
